// File: rtl/argmax_tree.sv
// argmax_tree -- pipelined argmax/argmin over N_IN channels.
//
// Purpose
//   Finds the winning channel (largest value in max mode, smallest in min
//   mode) of an N_IN-wide input vector using a binary compare tree with
//   one register rank per tree level (LAT = ceil(log2(N_IN)) ranks).
//   Ties resolve to the lower channel index. Every vector carries its own
//   mode, so max and min vectors can be mixed freely in the pipeline.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data/in_mode hold a vector
//   in_ready   out  block accepts a vector this cycle
//   in_data    in   N_IN*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_mode    in   0 = max, 1 = min
//   out_valid  out  out_value/out_idx hold a result
//   out_ready  in   downstream accepts the result this cycle
//   out_value  out  winning value (WIDTH)
//   out_idx    out  winning channel index (IDX_W)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. in_ready = ~(out_valid & ~out_ready); it does not depend on
// in_valid. While in_ready is low the whole pipeline freezes and in_valid
// is ignored. Bubbles (valid=0) advance like real vectors when not stalled.
module argmax_tree #(
    parameter int N_IN   = 6,
    parameter int WIDTH  = 25,
    parameter bit SIGNED = 1'b0,
    localparam int LAT   = $clog2(N_IN),
    localparam int IDX_W = (LAT > 1) ? LAT : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_value,
    output logic [IDX_W-1:0]      out_idx
);

    // Widest rank holds ceil(N_IN/2) nodes; later ranks use a prefix of it.
    localparam int HALF = (N_IN + 1) / 2;

    // Rank r holds the result of tree level r+1.
    logic [WIDTH-1:0] val_q  [LAT][HALF];
    logic [WIDTH-1:0] val_d  [LAT][HALF];
    logic [IDX_W-1:0] idx_q  [LAT][HALF];
    logic [IDX_W-1:0] idx_d  [LAT][HALF];
    logic             mode_q [LAT];
    logic             mode_d [LAT];
    logic             vld_q  [LAT];
    logic             vld_d  [LAT];

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // True when the right-hand (higher index) operand strictly beats the
    // left one; equality keeps the left, which gives lowest-index ties.
    // Signed compare is done by flipping the sign bits and comparing
    // unsigned.
    function automatic logic b_wins(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             mode);
        logic [WIDTH-1:0] ka;
        logic [WIDTH-1:0] kb;
        ka = a;
        kb = b;
        if (SIGNED) begin
            ka[WIDTH-1] = ~a[WIDTH-1];
            kb[WIDTH-1] = ~b[WIDTH-1];
        end
        return mode ? (kb < ka) : (kb > ka);
    endfunction

    always_comb begin : tree_comb
        logic [WIDTH-1:0] sv [N_IN];
        logic [IDX_W-1:0] si [N_IN];
        int               cnt;
        int               b;

        for (int r = 0; r < LAT; r++) begin
            for (int k = 0; k < HALF; k++) begin
                val_d[r][k] = '0;
                idx_d[r][k] = '0;
            end
            mode_d[r] = 1'b0;
            vld_d[r]  = 1'b0;
        end

        for (int r = 0; r < LAT; r++) begin
            // Gather this level's source nodes.
            for (int k = 0; k < N_IN; k++) begin
                sv[k] = '0;
                si[k] = '0;
            end
            if (r == 0) begin
                for (int k = 0; k < N_IN; k++) begin
                    sv[k] = in_data[k*WIDTH +: WIDTH];
                    si[k] = IDX_W'(k);
                end
                mode_d[r] = in_mode;
                vld_d[r]  = in_valid;
            end else begin
                for (int k = 0; k < HALF; k++) begin
                    sv[k] = val_q[(r > 0) ? r - 1 : 0][k];
                    si[k] = idx_q[(r > 0) ? r - 1 : 0][k];
                end
                mode_d[r] = mode_q[(r > 0) ? r - 1 : 0];
                vld_d[r]  = vld_q[(r > 0) ? r - 1 : 0];
            end

            // Number of live nodes entering this level.
            cnt = (N_IN + (1 << r) - 1) >> r;

            for (int k = 0; k < HALF; k++) begin
                b = (2*k + 1 < N_IN) ? 2*k + 1 : 2*k;
                if (2*k + 1 < cnt) begin
                    if (b_wins(sv[2*k], sv[b], mode_d[r])) begin
                        val_d[r][k] = sv[b];
                        idx_d[r][k] = si[b];
                    end else begin
                        val_d[r][k] = sv[2*k];
                        idx_d[r][k] = si[2*k];
                    end
                end else if (2*k < cnt) begin
                    // Odd leftover: registered pass-through keeps all
                    // paths at the same latency.
                    val_d[r][k] = sv[2*k];
                    idx_d[r][k] = si[2*k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < LAT; r++) begin
                for (int k = 0; k < HALF; k++) begin
                    val_q[r][k] <= '0;
                    idx_q[r][k] <= '0;
                end
                mode_q[r] <= 1'b0;
                vld_q[r]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int r = 0; r < LAT; r++) begin
                for (int k = 0; k < HALF; k++) begin
                    val_q[r][k] <= val_d[r][k];
                    idx_q[r][k] <= idx_d[r][k];
                end
                mode_q[r] <= mode_d[r];
                vld_q[r]  <= vld_d[r];
            end
        end
    end

    // Final rank is the output register.
    assign out_valid = vld_q[LAT-1];
    assign out_value = val_q[LAT-1][0];
    assign out_idx   = idx_q[LAT-1][0];

endmodule

// File: tb/tb_argmax_tree.sv
// tb_argmax_tree -- directed bench for argmax_tree.
// Three instances: 6 channels unsigned, 6 channels signed, 5 channels
// unsigned (odd pass-through). All have 8-bit values and LAT = 3.
module tb_argmax_tree;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        u_iv, u_ir, u_mode, u_ov, u_or;
    logic [47:0] u_data;
    logic [7:0]  u_val;
    logic [2:0]  u_idx;

    logic        s_iv, s_ir, s_mode, s_ov, s_or;
    logic [47:0] s_data;
    logic [7:0]  s_val;
    logic [2:0]  s_idx;

    logic        f_iv, f_ir, f_mode, f_ov, f_or;
    logic [39:0] f_data;
    logic [7:0]  f_val;
    logic [2:0]  f_idx;

    argmax_tree #(.N_IN(6), .WIDTH(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(u_iv), .in_ready(u_ir),
        .in_data(u_data), .in_mode(u_mode), .out_valid(u_ov),
        .out_ready(u_or), .out_value(u_val), .out_idx(u_idx));

    argmax_tree #(.N_IN(6), .WIDTH(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
        .in_data(s_data), .in_mode(s_mode), .out_valid(s_ov),
        .out_ready(s_or), .out_value(s_val), .out_idx(s_idx));

    argmax_tree #(.N_IN(5), .WIDTH(8), .SIGNED(1'b0)) dut_f (
        .clk(clk), .rst(rst), .in_valid(f_iv), .in_ready(f_ir),
        .in_data(f_data), .in_mode(f_mode), .out_valid(f_ov),
        .out_ready(f_or), .out_value(f_val), .out_idx(f_idx));

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  sel;      // 0 = unsigned6, 1 = signed6, 2 = unsigned5
        logic [47:0] data;     // {ch5,ch4,ch3,ch2,ch1,ch0}
        logic        mode;
        logic [7:0]  exp_val;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t tbl[16];

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic v,
                         input logic [47:0] d, input logic m);
        u_iv = 1'b0;
        s_iv = 1'b0;
        f_iv = 1'b0;
        case (sel)
            2'd0: begin u_iv = v; u_data = d; u_mode = m; end
            2'd1: begin s_iv = v; s_data = d; s_mode = m; end
            default: begin f_iv = v; f_data = d[39:0]; f_mode = m; end
        endcase
    endtask

    task automatic sample(input logic [1:0] sel, output logic ov,
                          output logic [7:0] v, output logic [2:0] ix);
        case (sel)
            2'd0: begin ov = u_ov; v = u_val; ix = u_idx; end
            2'd1: begin ov = s_ov; v = s_val; ix = s_idx; end
            default: begin ov = f_ov; v = f_val; ix = f_idx; end
        endcase
    endtask

    // Unsigned 6-channel reference: strict compare keeps the lowest index.
    function automatic logic [10:0] ref_model(input logic [47:0] d,
                                              input logic m);
        logic [7:0] bv;
        logic [2:0] bi;
        logic [7:0] c;
        bv = d[7:0];
        bi = 3'd0;
        for (int k = 1; k < 6; k++) begin
            c = d[k*8 +: 8];
            if (m ? (c < bv) : (c > bv)) begin
                bv = c;
                bi = 3'(k);
            end
        end
        return {bv, bi};
    endfunction

    function automatic logic [47:0] rand_vec();
        logic [47:0] d;
        for (int k = 0; k < 6; k++) d[k*8 +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        logic        ov;
        logic [7:0]  v;
        logic [2:0]  ix;
        logic [10:0] e;
        logic [47:0] rv[10];
        logic [47:0] d;

        tbl[0]  = '{"u_max_tie",    2'd0, {8'd2,8'd1,8'd9,8'd4,8'd9,8'd3}, 1'b0, 8'd9,   3'd1};
        tbl[1]  = '{"u_min",        2'd0, {8'd2,8'd1,8'd9,8'd4,8'd9,8'd3}, 1'b1, 8'd1,   3'd4};
        tbl[2]  = '{"u_max_alleq",  2'd0, {6{8'd7}},                       1'b0, 8'd7,   3'd0};
        tbl[3]  = '{"u_min_alleq",  2'd0, {6{8'd7}},                       1'b1, 8'd7,   3'd0};
        tbl[4]  = '{"u_max_last",   2'd0, {8'd255,8'd0,8'd0,8'd0,8'd0,8'd0}, 1'b0, 8'd255, 3'd5};
        tbl[5]  = '{"u_min_last",   2'd0, {8'd0,{5{8'd255}}},              1'b1, 8'd0,   3'd5};
        tbl[6]  = '{"u_max_hi",     2'd0, {8'hF0,8'hFF,8'h81,8'h80,8'hFE,8'hFF}, 1'b0, 8'hFF, 3'd0};
        tbl[7]  = '{"u_min_hi",     2'd0, {8'hF0,8'hFF,8'h81,8'h80,8'hFE,8'hFF}, 1'b1, 8'h80, 3'd2};
        tbl[8]  = '{"s_min_neg",    2'd1, {8'h80,8'h00,8'h80,8'h7F,8'hF0,8'h05}, 1'b1, 8'h80, 3'd3};
        tbl[9]  = '{"s_max_pos",    2'd1, {8'h80,8'h00,8'h80,8'h7F,8'hF0,8'h05}, 1'b0, 8'h7F, 3'd2};
        tbl[10] = '{"s_max_neg",    2'd1, {8'hF0,8'hFF,8'h81,8'h80,8'hFE,8'hFF}, 1'b0, 8'hFF, 3'd0};
        tbl[11] = '{"s_min_alleq",  2'd1, {6{8'h80}},                      1'b1, 8'h80,  3'd0};
        tbl[12] = '{"f_max_odd",    2'd2, {8'd0,8'd200,8'd150,8'd0,8'd199,8'd10}, 1'b0, 8'd200, 3'd4};
        tbl[13] = '{"f_min_odd",    2'd2, {8'd0,8'd200,8'd150,8'd0,8'd199,8'd10}, 1'b1, 8'd0,   3'd2};
        tbl[14] = '{"f_max_tie",    2'd2, {8'd0,8'd200,8'd5,8'd5,8'd5,8'd200},    1'b0, 8'd200, 3'd0};
        tbl[15] = '{"f_min_tie",    2'd2, {8'd0,8'd200,8'd5,8'd5,8'd5,8'd200},    1'b1, 8'd5,   3'd1};

        // ---- reset, with a vector presented during reset ----
        u_iv = 0; s_iv = 0; f_iv = 0;
        u_data = '0; s_data = '0; f_data = '0;
        u_mode = 0; s_mode = 0; f_mode = 0;
        u_or = 1; s_or = 1; f_or = 1;
        rst = 1'b1;
        drive(2'd0, 1'b1, {6{8'd255}}, 1'b0);
        tick();
        tick();
        chk("rst_u_valid", u_ov, 0);
        chk("rst_u_value", u_val, 0);
        chk("rst_u_idx",   u_idx, 0);
        chk("rst_u_ready", u_ir, 1);
        chk("rst_s_valid", s_ov, 0);
        chk("rst_s_value", s_val, 0);
        chk("rst_f_valid", f_ov, 0);
        chk("rst_f_idx",   f_idx, 0);
        rst = 1'b0;
        drive(2'd0, 1'b0, '0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("rst_discard", u_ov, 0);
        end

        // ---- table-driven single vectors ----
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].sel, 1'b1, tbl[i].data, tbl[i].mode);
            tick();
            drive(tbl[i].sel, 1'b0, tbl[i].data, tbl[i].mode);
            tick();
            sample(tbl[i].sel, ov, v, ix);
            chk({tbl[i].name, "_early"}, ov, 0);
            tick();
            sample(tbl[i].sel, ov, v, ix);
            chk({tbl[i].name, "_valid"}, ov, 1);
            chk({tbl[i].name, "_value"}, v, tbl[i].exp_val);
            chk({tbl[i].name, "_idx"},   ix, tbl[i].exp_idx);
        end
        drive(2'd0, 1'b0, '0, 1'b0);
        repeat (3) tick();

        // ---- back-to-back, alternating mode ----
        for (int i = 0; i < 10; i++) rv[i] = rand_vec();
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin
                drive(2'd0, 1'b1, rv[c], c[0]);
                exp_q.push_back(ref_model(rv[c], c[0]));
            end else begin
                drive(2'd0, 1'b0, '0, 1'b0);
            end
            tick();
            chk("b2b_valid", u_ov, (c >= 2 && c <= 11) ? 1 : 0);
            if (u_ov) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("b2b_value", u_val, e[10:3]);
                    chk("b2b_idx",   u_idx, e[2:0]);
                end
            end
        end
        chk("b2b_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) tick();

        // ---- backpressure: 4 stall cycles with a held input ----
        for (int c = 0; c < 3; c++) begin
            d = rand_vec();
            drive(2'd0, 1'b1, d, c[0]);
            exp_q.push_back(ref_model(d, c[0]));
            tick();
        end
        d = rand_vec();
        drive(2'd0, 1'b1, d, 1'b1);
        exp_q.push_back(ref_model(d, 1'b1));
        u_or = 1'b0;
        #1;
        chk("bp_ready_low", u_ir, 0);
        chk("bp_first_valid", u_ov, 1);
        chk("bp_first_value", u_val, exp_q[0][10:3]);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("bp_hold_ready", u_ir, 0);
            chk("bp_hold_valid", u_ov, 1);
            chk("bp_hold_value", u_val, exp_q[0][10:3]);
            chk("bp_hold_idx",   u_idx, exp_q[0][2:0]);
        end
        u_or = 1'b1;
        #1;
        chk("bp_release_ready", u_ir, 1);
        void'(exp_q.pop_front());
        tick();
        drive(2'd0, 1'b0, '0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (j < 3) begin
                chk("bp_drain_valid", u_ov, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bp_drain_value", u_val, e[10:3]);
                    chk("bp_drain_idx",   u_idx, e[2:0]);
                end else begin
                    chk("bp_drain_extra", 1, 0);
                end
            end else begin
                chk("bp_drain_done", u_ov, 0);
            end
            tick();
        end
        exp_q.delete();

        // ---- reset mid-stream ----
        for (int c = 0; c < 3; c++) begin
            drive(2'd0, 1'b1, rand_vec(), c[0]);
            tick();
        end
        rst = 1'b1;
        drive(2'd0, 1'b1, {6{8'd200}}, 1'b0);
        tick();
        chk("mrst_valid", u_ov, 0);
        chk("mrst_value", u_val, 0);
        chk("mrst_idx",   u_idx, 0);
        chk("mrst_ready", u_ir, 1);
        rst = 1'b0;
        drive(2'd0, 1'b0, '0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("mrst_no_stale", u_ov, 0);
        end
        d = {8'd11,8'd22,8'd99,8'd44,8'd55,8'd66};
        drive(2'd0, 1'b1, d, 1'b0);
        tick();
        drive(2'd0, 1'b0, '0, 1'b0);
        tick();
        chk("mrst_new_early", u_ov, 0);
        tick();
        chk("mrst_new_valid", u_ov, 1);
        chk("mrst_new_value", u_val, 8'd99);
        chk("mrst_new_idx",   u_idx, 3'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/argmax_tree.md
ARGMAX_TREE -- requirements
Module: argmax_tree

Interface
REQ-001 Parameter N_IN, default 6: number of input channels; legal range 2..64.
REQ-002 Parameter WIDTH, default 25: bit width of each channel value.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 Derived constants are IDX_W = max(1, ceil(log2(N_IN)))) and LAT = ceil(log2(N_IN)); they SHALL NOT be overridable.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  in_data and in_mode hold a vector to evaluate.
REQ-008 in_ready  output  1  block accepts a vector this cycle.
REQ-009 in_data  input  N_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_mode  input  1  0 = find maximum, 1 = find minimum; sampled per vector.
REQ-011 out_valid  output  1  out_value and out_idx hold a result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 out_value  output  WIDTH  winning channel value.
REQ-014 out_idx  output  IDX_W  winning channel index.

Function
REQ-015 The datapath SHALL be a binary compare tree with exactly one register rank per tree level, LAT ranks in total (N_IN=6 -> 3 ranks).
REQ-016 At each level, adjacent pairs SHALL be compared; an odd leftover element SHALL pass through that level registered, without comparison, so that all paths have equal latency.
REQ-017 Each tree node SHALL carry {value, index, mode, valid}; mode and valid travel alongside the data.
REQ-018 Max mode: the winner is the larger value; min mode: the winner is the smaller value; compare signedness follows SIGNED.
REQ-019 Ties in either mode SHALL resolve to the lower channel index.
REQ-020 Stall condition: stall = out_valid & ~out_ready; in_ready = ~stall.
REQ-021 The handshake rules are:
- a vector is accepted only when in_valid & in_ready;
- when in_ready is low, in_valid is ignored and no vector is captured.
REQ-022 On stall, all pipeline ranks and outputs SHALL hold their values; otherwise every rank advances by one each cycle, including bubbles (valid=0).
REQ-023 Latency: a vector accepted in cycle t SHALL appear on the outputs in cycle t+LAT when no stall occurs; each stall cycle adds one cycle.
REQ-024 Throughput SHALL be one vector per cycle with no stall; results SHALL leave in acceptance order and none may be dropped or duplicated.
REQ-025 out_value and out_idx SHALL be registered outputs taken from the final rank; when out_valid=0 their values are don't-care, but they SHALL NOT be X after reset.
REQ-026 The mode of each vector SHALL apply only to that vector, so mixed max/min vectors in flight SHALL each be computed correctly.

Reset
REQ-027 While rst=1 at a rising edge, all rank valid bits and out_valid SHALL clear to 0, and out_value, out_idx and all rank data/index/mode registers SHALL clear to 0.
REQ-028 While rst=1, in_ready SHALL be 1 (since out_valid=0), and any vector presented in that cycle SHALL be discarded.
REQ-029 Assertion of rst mid-operation SHALL discard all in-flight vectors; the first output after rst deasserts SHALL come from a vector accepted after the deassertion.

Verification (N_IN=6, WIDTH=8 unless stated)
REQ-030 Basic max: unsigned, mode=0, in_data ch0..5 = {3,9,4,9,1,2} accepted at t -> at t+3 out_valid=1, out_value=9, out_idx=1 (tie resolves to the lower index).
REQ-031 Min with SIGNED=1: mode=1, ch0..5 = {0x05,0xF0,0x7F,0x80,0x00,0x80} -> out_value=0x80 (-128), out_idx=3.
REQ-032 Back-to-back traffic: 10 random vectors on consecutive cycles with alternating mode, out_ready=1 -> 10 results on consecutive cycles from t+3, each matching the reference-model max/min and index.
REQ-033 Backpressure: out_ready=0 for 4 cycles while a result is valid -> in_ready=0 during those cycles, outputs stable, no loss; order is preserved after release.
REQ-034 Reset mid-stream: 3 vectors in flight, then rst=1 for 1 cycle -> out_valid=0 next cycle, outputs 0, and no stale result ever emerges.
REQ-035 Odd pass-through with N_IN=5 (LAT=3): ch4 is the unique max 200, others < 200 -> out_value=200, out_idx=4 at t+3.
